sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single `memory_controller` SDRAM port among NUM_REQ requesters (e.g. video fetch, CPU, DMA).
- Round-robin arbitration; one transaction outstanding at a time.
- Latches the winner's cmd/addr/wdata, pulses `ready` to the controller, waits for `valid`, then returns done and read data to the owner.
- Sits between client logic and `memory_controller`; the top level converts mc_wdata/mc_rdata to and from the controller's bidirectional dq.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort; used only with SDRAM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  50 MHz system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request, level; held until req_ack.
- req_cmd  in  2*NUM_REQ  one-hot cmd per requester: 2'b10 = WRITE, 2'b01 = READ.
- req_addr  in  25*NUM_REQ  address per requester.
- req_wdata  in  16*NUM_REQ  write data per requester.
- req_ack  out  NUM_REQ  one-cycle pulse: request accepted.
- req_done  out  NUM_REQ  one-cycle pulse: transaction finished.
- req_err  out  1  qualifies req_done: transaction failed.
- rsp_rdata  out  16  read data; valid while req_done is high.
- mc_cmd  out  2  to controller `cmd`.
- mc_addr  out  25  to controller `addr`.
- mc_wdata  out  16  write data toward controller dq.
- mc_ready  out  1  to controller `ready`; one-cycle pulse.
- mc_rdata  in  16  read data from controller dq.
- mc_valid  in  1  controller `valid`; command complete.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs 0: req_ack, req_done, req_err, rsp_rdata, mc_cmd, mc_addr, mc_wdata, mc_ready, busy.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
  - An in-flight transaction is abandoned; no req_done is issued for it.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from last+1 (mod NUM_REQ) → grant g.
  - Register req_cmd[g], req_addr[g], req_wdata[g] into mc_cmd/mc_addr/mc_wdata, and g into the grant register.
  - Legal cmd (2'b10 or 2'b01) → ISSUE.
  - Illegal cmd (2'b00 or 2'b11) → DONE with err flag set; mc_ready is never pulsed.
- ISSUE (exactly 1 cycle):
  - mc_ready=1 and req_ack[g]=1.
  - mc_cmd/mc_addr/mc_wdata are already stable from the previous edge and are held through WAIT.
  - → WAIT.
- WAIT:
  - mc_ready=0.
  - On mc_valid=1: capture mc_rdata into rsp_rdata, err=0 → DONE.
- DONE (exactly 1 cycle):
  - req_done[g]=1, req_err=err, rsp_rdata valid.
  - For illegal-cmd aborts, req_ack[g] is pulsed here, since ISSUE was skipped.
  - last ← g → IDLE.
  - mc_cmd returns to 2'b00.
- Latency:
  - req_valid seen in IDLE at cycle n → mc_ready and req_ack at n+1.
  - mc_valid at cycle m → req_done at m+1.
  - Minimum gap between back-to-back grants: IDLE is revisited for 1 cycle after every DONE.
- Requester rule:
  - req_valid must drop the cycle after req_ack.
  - If it is still high when the FSM returns to IDLE, it is treated as a new request.
  - Changes to req_* after the grant edge have no effect on the current transaction.
- Simultaneous requests: round-robin guarantees each pending requester is served within NUM_REQ grants.
- mc_valid outside WAIT: ignored, no state change.
- mc_valid in the same cycle as rst: reset wins.
- Exactly one bit of req_ack and req_done may be high in any cycle.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mc_valid: → DONE with req_err=1, rsp_rdata=16'h0000.
  - A late mc_valid is then ignored.
- Undefined:
  - No counter; WAIT holds indefinitely until mc_valid or rst.

Test Plan:
1. Reset then single write: req0 cmd=2'b10, addr=25'h0FFFF, wdata=16'hAAAA → next cycle mc_ready=1, req_ack[0]=1, mc_addr=25'h0FFFF, mc_wdata=16'hAAAA. mc_valid 6 cycles later → req_done[0]=1 next cycle, req_err=0.
2. Read: req1 cmd=2'b01, addr=25'h00010; model returns mc_rdata=16'h5A5A with mc_valid → req_done[1]=1, rsp_rdata=16'h5A5A.
3. Contention: req0 and req1 held high continuously from reset → grants in order 0,1,0,1; never two grants to the same requester while the other is pending.
4. Illegal cmd: req0 cmd=2'b11 → mc_ready never pulses; req_ack[0] and req_done[0] both in DONE cycle with req_err=1.
5. Reset mid-op: rst asserted in WAIT → next cycle busy=0 and all outputs 0; no req_done; the next grant goes to requester 0.
6. With SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mc_valid held low → req_done with req_err=1 after 8 WAIT cycles. A later mc_valid pulse → no response.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one memory_controller port among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [2*NUM_REQ-1:0]    req_cmd,
    input  logic [25*NUM_REQ-1:0]   req_addr,
    input  logic [16*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic [NUM_REQ-1:0]      req_done,
    output logic                    req_err,
    output logic [15:0]             rsp_rdata,
    output logic [1:0]              mc_cmd,
    output logic [24:0]             mc_addr,
    output logic [15:0]             mc_wdata,
    output logic                    mc_ready,
    input  logic [15:0]             mc_rdata,
    input  logic                    mc_valid,
    output logic                    busy
);

    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b01;

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("sdram_arbiter: illegal parameter value");
    end

    logic [1:0]       cmd_arr   [NUM_REQ];
    logic [24:0]      addr_arr  [NUM_REQ];
    logic [15:0]      wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign cmd_arr[i]   = req_cmd[2*i +: 2];
        assign addr_arr[i]  = req_addr[25*i +: 25];
        assign wdata_arr[i] = req_wdata[16*i +: 16];
    end

    logic [1:0]       state_q,     state_d;
    logic [IDX_W-1:0] last_q,      last_d;
    logic [IDX_W-1:0] grant_q,     grant_d;
    logic [1:0]       mc_cmd_q,    mc_cmd_d;
    logic [24:0]      mc_addr_q,   mc_addr_d;
    logic [15:0]      mc_wdata_q,  mc_wdata_d;
    logic [15:0]      rsp_rdata_q, rsp_rdata_d;
    logic             err_q,       err_d;
    logic             skip_q,      skip_d;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // First pending requester strictly after the last winner, wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] c;
        logic [IDX_W-1:0] sel;
        logic             hit;
        sel = '0;
        hit = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = IDX_W'((int'(last) + i) % NUM_REQ);
            if (!hit && v[c]) begin
                hit = 1'b1;
                sel = c;
            end
        end
        return sel;
    endfunction

    logic [IDX_W-1:0] pick;
    logic [1:0]       pick_cmd;
    logic             pick_legal;

    assign pick       = rr_pick(req_valid, last_q);
    assign pick_cmd   = cmd_arr[pick];
    assign pick_legal = (pick_cmd == CMD_WRITE) || (pick_cmd == CMD_READ);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        mc_cmd_d    = mc_cmd_q;
        mc_addr_d   = mc_addr_q;
        mc_wdata_d  = mc_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = err_q;
        skip_d      = skip_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d    = pick;
                    mc_addr_d  = addr_arr[pick];
                    mc_wdata_d = wdata_arr[pick];
                    if (pick_legal) begin
                        mc_cmd_d = pick_cmd;
                        err_d    = 1'b0;
                        skip_d   = 1'b0;
                        state_d  = S_ISSUE;
                    end else begin
                        // Illegal command never reaches the controller.
                        mc_cmd_d    = 2'b00;
                        err_d       = 1'b1;
                        skip_d      = 1'b1;
                        rsp_rdata_d = 16'h0000;
                        state_d     = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
`ifdef SDRAM_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mc_valid) begin
                    rsp_rdata_d = mc_rdata;
                    err_d       = 1'b0;
                    mc_cmd_d    = 2'b00;
                    state_d     = S_DONE;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rdata_d = 16'h0000;
                    err_d       = 1'b1;
                    mc_cmd_d    = 2'b00;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            grant_q     <= '0;
            mc_cmd_q    <= 2'b00;
            mc_addr_q   <= '0;
            mc_wdata_q  <= '0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
            skip_q      <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            mc_cmd_q    <= mc_cmd_d;
            mc_addr_q   <= mc_addr_d;
            mc_wdata_q  <= mc_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
            skip_q      <= skip_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    logic [NUM_REQ-1:0] grant_oh;
    assign grant_oh = NUM_REQ'(1) << grant_q;

    // Aborted illegal commands skip ISSUE, so their ack lands in DONE together with done.
    assign req_ack   = ((state_q == S_ISSUE) || (state_q == S_DONE && skip_q)) ? grant_oh : '0;
    assign req_done  = (state_q == S_DONE) ? grant_oh : '0;
    assign req_err   = (state_q == S_DONE) && err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mc_cmd    = mc_cmd_q;
    assign mc_addr   = mc_addr_q;
    assign mc_wdata  = mc_wdata_q;
    assign mc_ready  = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: vector table for single transactions plus
// hand-written contention, reset-abort and WAIT-hold/timeout sequences.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [3:0]  req_cmd;
    logic [49:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_ack;
    logic [1:0]  req_done;
    logic        req_err;
    logic [15:0] rsp_rdata;
    logic [1:0]  mc_cmd;
    logic [24:0] mc_addr;
    logic [15:0] mc_wdata;
    logic        mc_ready;
    logic [15:0] mc_rdata;
    logic        mc_valid;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    sdram_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_done(req_done), .req_err(req_err), .rsp_rdata(rsp_rdata),
        .mc_cmd(mc_cmd), .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
        .mc_rdata(mc_rdata), .mc_valid(mc_valid), .busy(busy)
    );

    typedef struct {
        logic        r;
        logic [1:0]  cmd;
        logic [24:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          dly;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic r, input logic [1:0] cmd, input logic [24:0] addr,
                           input logic [15:0] wdata);
        if (r) begin
            req_cmd[3:2]    = cmd;
            req_addr[49:25] = addr;
            req_wdata[31:16] = wdata;
        end else begin
            req_cmd[1:0]    = cmd;
            req_addr[24:0]  = addr;
            req_wdata[15:0] = wdata;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(mc_ready), 32'd0);
        check({tag, "_ack"},   32'(req_ack), 32'd0);
        check({tag, "_done"},  32'(req_done), 32'd0);
        check({tag, "_err"},   32'(req_err), 32'd0);
        check({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
        check({tag, "_cmd"},   32'(mc_cmd), 32'd0);
        check({tag, "_addr"},  32'(mc_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mc_wdata), 32'd0);
    endtask

    // Called at a negedge with the FSM in IDLE; returns at a negedge in IDLE.
    task automatic run_vec(input vec_t v);
        logic [1:0] oh;
        logic       legal;
        oh    = v.r ? 2'b10 : 2'b01;
        legal = (v.cmd == 2'b10) || (v.cmd == 2'b01);
        set_req(v.r, v.cmd, v.addr, v.wdata);
        req_valid = oh;
        @(negedge clk);
        if (legal) begin
            check("issue_ready", 32'(mc_ready), 32'd1);
            check("issue_ack",   32'(req_ack), 32'(oh));
            check("issue_cmd",   32'(mc_cmd), 32'(v.cmd));
            check("issue_addr",  32'(mc_addr), 32'(v.addr));
            check("issue_wdata", 32'(mc_wdata), 32'(v.wdata));
            check("issue_done",  32'(req_done), 32'd0);
            req_valid = 2'b00;
            for (int k = 1; k <= v.dly; k++) begin
                @(negedge clk);
                check("wait_state", 32'({busy, mc_ready, req_ack, req_done}), 32'h20);
                if (k == v.dly) begin
                    mc_valid = 1'b1;
                    mc_rdata = v.rdata;
                end
            end
            @(negedge clk);
            mc_valid = 1'b0;
            mc_rdata = 16'h0;
            check("done_pulse", 32'(req_done), 32'(oh));
            check("done_ack",   32'(req_ack), 32'd0);
            check("done_cmd",   32'(mc_cmd), 32'd0);
        end else begin
            check("abort_ready", 32'(mc_ready), 32'd0);
            check("abort_ack",   32'(req_ack), 32'(oh));
            check("abort_done",  32'(req_done), 32'(oh));
            check("abort_cmd",   32'(mc_cmd), 32'd0);
            req_valid = 2'b00;
        end
        check("done_err",   32'(req_err), 32'(v.exp_err));
        check("done_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
        @(negedge clk);
        check("back_idle", 32'({busy, mc_ready, req_ack, req_done}), 32'h0);
    endtask

    // Advance negedges until an ack appears; bounded.
    task automatic wait_ack(input string name);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 8 && !seen; t++) begin
            @(negedge clk);
            if (req_ack != 2'b00) seen = 1'b1;
        end
        check({name, "_ack_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 2'b10, 25'h000FFFF, 16'hAAAA, 16'h0000, 6, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 2'b01, 25'h0000010, 16'h0000, 16'h5A5A, 2, 1'b0, 16'h5A5A};
        tbl[2] = '{1'b0, 2'b11, 25'h0001234, 16'h1111, 16'h0000, 0, 1'b1, 16'h0000};
        tbl[3] = '{1'b1, 2'b00, 25'h1ABCDEF, 16'h2222, 16'h0000, 0, 1'b1, 16'h0000};
        tbl[4] = '{1'b1, 2'b10, 25'h1FFFFFF, 16'hFFFF, 16'h3C3C, 1, 1'b0, 16'h3C3C};
        tbl[5] = '{1'b0, 2'b01, 25'h0000000, 16'h0000, 16'hFFFF, 3, 1'b0, 16'hFFFF};

        rst       = 1'b1;
        req_valid = 2'b00;
        req_cmd   = '0;
        req_addr  = '0;
        req_wdata = '0;
        mc_rdata  = 16'h0;
        mc_valid  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // mc_valid while IDLE must be ignored
        mc_valid = 1'b1;
        mc_rdata = 16'hDEAD;
        @(negedge clk);
        mc_valid = 1'b0;
        check("stray_valid_busy", 32'(busy), 32'd0);
        check("stray_valid_done", 32'(req_done), 32'd0);
        @(negedge clk);
        check("stray_valid_rdata", 32'(rsp_rdata), 32'hFFFF);

        // Contention: both requesters pending from reset
        rst = 1'b1;
        set_req(1'b0, 2'b01, 25'h0000100, 16'h0);
        set_req(1'b1, 2'b01, 25'h0000200, 16'h0);
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            wait_ack("rr");
            check("rr_order", 32'(req_ack), (g % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_addr",  32'(mc_addr), (g % 2 == 0) ? 32'h100 : 32'h200);
            @(negedge clk);
            mc_valid = 1'b1;
            mc_rdata = 16'(g + 16'h00A0);
            @(negedge clk);
            mc_valid = 1'b0;
            check("rr_done",  32'(req_done), (g % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_rdata", 32'(rsp_rdata), 32'(g + 16'h00A0));
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

        // Reset during WAIT, with mc_valid colliding with rst
        set_req(1'b1, 2'b01, 25'h0000777, 16'h0);
        req_valid = 2'b10;
        @(negedge clk);
        check("rmo_ack", 32'(req_ack), 32'd2);
        req_valid = 2'b00;
        @(negedge clk);
        rst      = 1'b1;
        mc_valid = 1'b1;
        mc_rdata = 16'hBEEF;
        @(negedge clk);
        check_idle_outputs("rmo");
        rst      = 1'b0;
        mc_valid = 1'b0;
        @(negedge clk);
        check("rmo_no_done", 32'({busy, req_done}), 32'd0);
        set_req(1'b0, 2'b10, 25'h0000055, 16'h1234);
        req_valid = 2'b11;
        @(negedge clk);
        check("rmo_next_grant", 32'(req_ack), 32'd1);
        req_valid = 2'b00;
        @(negedge clk);
        mc_valid = 1'b1;
        mc_rdata = 16'h0000;
        @(negedge clk);
        mc_valid = 1'b0;
        check("rmo_done", 32'(req_done), 32'd1);
        @(negedge clk);

        // Long WAIT: watchdog abort when enabled, indefinite hold otherwise
        set_req(1'b0, 2'b01, 25'h0000003, 16'h0);
        req_valid = 2'b01;
        @(negedge clk);
        check("long_ack", 32'(req_ack), 32'd1);
        req_valid = 2'b00;
`ifdef SDRAM_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("to_waiting", 32'({busy, req_done}), 32'h4);
        end
        @(negedge clk);
        check("to_done",  32'(req_done), 32'd1);
        check("to_err",   32'(req_err), 32'd1);
        check("to_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge clk);
        mc_valid = 1'b1;
        mc_rdata = 16'h7777;
        @(negedge clk);
        mc_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("to_late_valid", 32'({busy, req_done, req_err}), 32'd0);
            @(negedge clk);
        end
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("hold_waiting", 32'({busy, req_done}), 32'h4);
        end
        mc_valid = 1'b1;
        mc_rdata = 16'h0F0F;
        @(negedge clk);
        mc_valid = 1'b0;
        check("hold_done",  32'(req_done), 32'd1);
        check("hold_err",   32'(req_err), 32'd0);
        check("hold_rdata", 32'(rsp_rdata), 32'h0F0F);
        @(negedge clk);
        check("hold_idle", 32'(busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
